uart_transceiver: RTL and testbench
===================================

// Module: uart_transceiver
// PURPOSE
//   8N1 UART transmitter and receiver sharing one clock domain; memory-mapped UART peripheral of the SoC.
//   TX serialises a byte on a one-cycle strobe and reports busy/done.
//   RX deserialises line data and presents each byte with a one-cycle valid pulse.
//   TX and RX are fully independent (full duplex).
// PARAMETERS
//   CLKS_PER_BIT  234  clock cycles per bit. 27 MHz / 115200 baud. Must be >= 4.
// PORTS
//   i_Clock      in   1  system clock; all logic on its rising edge.
//   i_Rst_L      in   1  reset; asynchronous assert, active-low.
//   i_Tx_DV      in   1  one-cycle request to send i_Tx_Byte.
//   i_Tx_Byte    in   8  byte to transmit; sampled only on an accepted i_Tx_DV.
//   o_Tx_Active  out  1  high while a TX frame is in progress (busy).
//   o_Tx_Serial  out  1  serial line out; idles high.
//   o_Tx_Done    out  1  one-cycle pulse at end of stop bit.
//   i_Rx_Serial  in   1  asynchronous serial line in; idles high.
//   o_Rx_DV      out  1  one-cycle pulse when a valid byte is received.
//   o_Rx_Byte    out  8  last received byte; held until the next valid frame.
// BEHAVIOUR
//   Reset (i_Rst_L=0, async):
//   - o_Tx_Serial=1; o_Tx_Active=0; o_Tx_Done=0; o_Rx_DV=0; o_Rx_Byte=0.
//   - Both FSMs go to IDLE; counters are cleared.
//   - Reset mid-frame aborts the frame; no Done/DV pulse follows.
//   Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity. Each bit lasts CLKS_PER_BIT cycles.
//   TX FSM (IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE):
//   - IDLE: line=1. i_Tx_DV=1 latches i_Tx_Byte, enters START.
//   - o_Tx_Active and the start bit (line=0) begin on the next edge.
//   - START: line=0 for CLKS_PER_BIT cycles.
//   - DATA: bit index 0..7, each held CLKS_PER_BIT cycles.
//   - STOP: line=1 for CLKS_PER_BIT cycles. On its last cycle, o_Tx_Done pulses for 1 cycle and o_Tx_Active drops.
//   - CLEANUP: 1 cycle, line=1, then IDLE.
//   - i_Tx_DV outside IDLE is ignored; no queueing, the byte is dropped.
//   - Frame length from accept to IDLE: 10*CLKS_PER_BIT+2 cycles.
//   RX FSM (IDLE -> START -> DATA -> STOP -> CLEANUP -> IDLE):
//   - i_Rx_Serial passes a 2-flop synchroniser; all decisions use the synchronised value.
//   - IDLE: a low level enters START with the counter at 0.
//   - START: at count (CLKS_PER_BIT-1)/2 (mid-bit), enter DATA if the line is still 0. Otherwise the pulse is a glitch: return to IDLE.
//   - DATA: sample every CLKS_PER_BIT cycles from mid-start, i.e. at mid-bit. Shift LSB first into a shadow register.
//   - STOP: sample mid stop bit.
//     - 1: copy the shadow register to o_Rx_Byte and pulse o_Rx_DV for exactly 1 cycle.
//     - 0: framing error; discard the byte, no DV, o_Rx_Byte unchanged.
//   - CLEANUP: 1 cycle, then IDLE. A new start bit is accepted from the cycle after.
//   - Break (line held 0): at most one framing error per start edge. No spurious DV.
//   Counters: width $clog2(CLKS_PER_BIT)+1; wrap to 0 at CLKS_PER_BIT-1.
//   Simultaneous TX and RX activity: fully independent, no arbitration.
// STRUCTURE
//   Package uart_pkg:
//   - TX/RX state encodings (IDLE, START, DATA, STOP, CLEANUP, 3 bits).
//   - Frame constants: DATA_BITS=8, START_LVL=0, STOP_LVL=1.
//   Two sub-modules instantiated by uart_transceiver, one per direction, no shared state:
//   - uart_tx_core: TX FSM.
//   - uart_rx_core: synchroniser and RX FSM.
// TESTING
//   All cases use CLKS_PER_BIT=8.
//   1. Reset: hold i_Rst_L=0 with i_Rx_Serial=1 -> o_Tx_Serial=1, o_Tx_Active=0, o_Rx_DV=0, o_Rx_Byte=0x00.
//   2. TX 0xA5, 1-cycle i_Tx_DV:
//      - o_Tx_Active next edge.
//      - Line reads 0,1,0,1,0,0,1,0,1,1, each 8 cycles.
//      - One o_Tx_Done pulse; Active low after the stop bit.
//   3. TX busy: second i_Tx_DV (0x3C) mid-frame -> ignored. Only 0xA5 appears on the line; one Done pulse.
//   4. Loopback o_Tx_Serial->i_Rx_Serial, send 0x00, 0xFF, 0x55 back-to-back -> three o_Rx_DV pulses; o_Rx_Byte=0x00, 0xFF, 0x55.
//   5. RX glitch (low for 2 cycles) then frame 0x81 with bad stop bit (0):
//      - No o_Rx_DV; o_Rx_Byte unchanged.
//      - A following good frame 0x42 -> DV, o_Rx_Byte=0x42.
//   6. Async reset mid-TX (after bit 3) -> o_Tx_Serial=1 and Active=0 immediately; no Done; a new request after reset sends a full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encodings and 8N1 frame constants for the UART cores
package uart_pkg;
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_STOP    = 3'd3,
        ST_CLEANUP = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS = 8;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;
endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - synchronised 8N1 deserialiser with mid-bit sampling and framing check
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_serial,
    output logic                 rx_dv,
    output logic [DATA_BITS-1:0] rx_byte
);
    localparam int            CW       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'((CLKS_PER_BIT - 1) / 2);

    logic                   meta_q, sync_q;
    uart_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shadow_q, shadow_d;
    logic [DATA_BITS-1:0]   byte_q, byte_d;
    logic                   dv_q, dv_d;
    logic                   brk_q, brk_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        // after a framing error the line must return high before a new start counts
        brk_d    = (sync_q == STOP_LVL) ? 1'b0 : brk_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (sync_q == START_LVL && !brk_q) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d   = '0;
                    state_d = (sync_q == START_LVL) ? ST_DATA : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    shadow_d = {sync_q, shadow_q[DATA_BITS-1:1]};
                    if (idx_q == 3'(DATA_BITS - 1)) state_d = ST_STOP;
                    else                            idx_d   = idx_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CLEANUP;
                    if (sync_q == STOP_LVL) begin
                        byte_d = shadow_q;
                        dv_d   = 1'b1;
                    end else begin
                        brk_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CLEANUP: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q   <= STOP_LVL;
            sync_q   <= STOP_LVL;
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            meta_q   <= rx_serial;
            sync_q   <= meta_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            brk_q    <= brk_d;
        end
    end

    assign rx_dv   = dv_q;
    assign rx_byte = byte_q;
endmodule

// File: rtl/uart_tx_core.sv
// rtl/uart_tx_core.sv - 8N1 serialiser; one byte per accepted strobe, busy while framing
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_dv,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 tx_active,
    output logic                 tx_serial,
    output logic                 tx_done
);
    localparam int            CW       = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

    uart_state_e            state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   active_q, active_d;
    logic                   serial_q, serial_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        active_d = active_q;
        serial_d = serial_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                serial_d = STOP_LVL;
                active_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
                if (tx_dv) begin
                    data_d   = tx_byte;
                    state_d  = ST_START;
                    serial_d = START_LVL;
                    active_d = 1'b1;
                end
            end
            ST_START: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = ST_DATA;
                    serial_d = data_q[0];
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DATA: begin
                // data_q shifts right so the next bit to send is always at [1]
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 3'(DATA_BITS - 1)) begin
                        state_d  = ST_STOP;
                        serial_d = STOP_LVL;
                    end else begin
                        idx_d    = idx_q + 3'd1;
                        serial_d = data_q[1];
                        data_d   = {1'b0, data_q[DATA_BITS-1:1]};
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_PRE) begin
                    done_d   = 1'b1;
                    active_d = 1'b0;
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_CLEANUP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_CLEANUP: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            active_q <= 1'b0;
            serial_q <= STOP_LVL;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            active_q <= active_d;
            serial_q <= serial_d;
            done_q   <= done_d;
        end
    end

    assign tx_active = active_q;
    assign tx_serial = serial_q;
    assign tx_done   = done_q;
endmodule

// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART built from independent TX and RX cores
module uart_transceiver #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Tx_DV,
    input  logic [7:0] i_Tx_Byte,
    output logic       o_Tx_Active,
    output logic       o_Tx_Serial,
    output logic       o_Tx_Done,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte
);
    uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk       (i_Clock),
        .rst_n     (i_Rst_L),
        .tx_dv     (i_Tx_DV),
        .tx_byte   (i_Tx_Byte),
        .tx_active (o_Tx_Active),
        .tx_serial (o_Tx_Serial),
        .tx_done   (o_Tx_Done)
    );

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (i_Clock),
        .rst_n     (i_Rst_L),
        .rx_serial (i_Rx_Serial),
        .rx_dv     (o_Rx_DV),
        .rx_byte   (o_Rx_Byte)
    );
endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - directed table-driven bench for uart_transceiver
module tb_uart_transceiver;
    localparam int CPB = 8;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       tx_dv   = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_active, tx_serial, tx_done;
    logic       rx_serial, rx_dv;
    logic [7:0] rx_byte;
    logic       loop_en = 1'b0;
    logic       rx_drv  = 1'b1;

    assign rx_serial = loop_en ? tx_serial : rx_drv;

    always #5 clk = ~clk;

    uart_transceiver #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Rst_L     (rst_n),
        .i_Tx_DV     (tx_dv),
        .i_Tx_Byte   (tx_byte),
        .o_Tx_Active (tx_active),
        .o_Tx_Serial (tx_serial),
        .o_Tx_Done   (tx_done),
        .i_Rx_Serial (rx_serial),
        .o_Rx_DV     (rx_dv),
        .o_Rx_Byte   (rx_byte)
    );

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int dv_cnt   = 0;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (rx_dv)   dv_cnt++;
    end

    typedef struct {
        logic [7:0] tx;
        logic [9:0] frame;     // line level of bit k at frame[k], start first
        logic [7:0] exp_rx;
        logic       inj;
        logic [7:0] inj_byte;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int d0, r0;
        logic [9:0] got;
        d0 = done_cnt;
        r0 = dv_cnt;
        got = '0;
        tx_byte = v.tx;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        check({tag, " active_next_edge"}, 32'(tx_active), 32'd1);
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            got[k] = tx_serial;
            if (k == 2 && v.inj) begin
                tx_byte = v.inj_byte;
                tx_dv   = 1'b1;
                @(negedge clk);
                tx_dv   = 1'b0;
                repeat (CPB - 1) @(negedge clk);
            end else if (k < 9) begin
                repeat (CPB) @(negedge clk);
            end
        end
        repeat (6) @(negedge clk);
        check({tag, " frame"}, 32'(got), 32'(v.frame));
        check({tag, " active_after"}, 32'(tx_active), 32'd0);
        check({tag, " done_pulses"}, 32'(done_cnt - d0), 32'd1);
        check({tag, " rx_dv_pulses"}, 32'(dv_cnt - r0), loop_en ? 32'd1 : 32'd0);
        if (loop_en) check({tag, " rx_byte"}, 32'(rx_byte), 32'(v.exp_rx));
        if (v.inj) begin
            repeat (20) @(negedge clk);
            check({tag, " no_queued_frame"}, 32'({tx_active, tx_serial}), 32'b01);
        end
    endtask

    task automatic rx_send(input logic [9:0] f);
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            repeat (CPB) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        int r0, d0;
        vecs[0] = '{tx: 8'hA5, frame: 10'b1101001010, exp_rx: 8'hA5, inj: 1'b0, inj_byte: 8'h00};
        vecs[1] = '{tx: 8'hA5, frame: 10'b1101001010, exp_rx: 8'hA5, inj: 1'b1, inj_byte: 8'h3C};
        vecs[2] = '{tx: 8'h00, frame: 10'b1000000000, exp_rx: 8'h00, inj: 1'b0, inj_byte: 8'h00};
        vecs[3] = '{tx: 8'hFF, frame: 10'b1111111110, exp_rx: 8'hFF, inj: 1'b0, inj_byte: 8'h00};
        vecs[4] = '{tx: 8'h55, frame: 10'b1010101010, exp_rx: 8'h55, inj: 1'b0, inj_byte: 8'h00};

        repeat (3) @(negedge clk);
        check("reset tx_serial", 32'(tx_serial), 32'd1);
        check("reset tx_active", 32'(tx_active), 32'd0);
        check("reset tx_done", 32'(tx_done), 32'd0);
        check("reset rx_dv", 32'(rx_dv), 32'd0);
        check("reset rx_byte", 32'(rx_byte), 32'h00);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        loop_en = 1'b1;
        for (int i = 0; i < 5; i++) run_frame(vecs[i], $sformatf("vec%0d", i));
        loop_en = 1'b0;
        repeat (10) @(negedge clk);

        r0 = dv_cnt;
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch no_dv", 32'(dv_cnt - r0), 32'd0);
        rx_send(10'b0100000010);
        repeat (30) @(negedge clk);
        check("bad_stop no_dv", 32'(dv_cnt - r0), 32'd0);
        check("bad_stop byte_held", 32'(rx_byte), 32'h55);
        rx_send(10'b1010000100);
        repeat (20) @(negedge clk);
        check("good_after_bad dv", 32'(dv_cnt - r0), 32'd1);
        check("good_after_bad byte", 32'(rx_byte), 32'h42);

        r0 = dv_cnt;
        rx_drv = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        check("break no_dv", 32'(dv_cnt - r0), 32'd0);
        check("break byte_held", 32'(rx_byte), 32'h42);

        d0 = done_cnt;
        tx_byte = 8'h0F;
        tx_dv   = 1'b1;
        @(negedge clk);
        tx_dv   = 1'b0;
        repeat (5 * CPB + CPB / 2) @(negedge clk);
        check("pre_reset line", 32'(tx_serial), 32'd0);
        check("pre_reset active", 32'(tx_active), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset line", 32'(tx_serial), 32'd1);
        check("mid_reset active", 32'(tx_active), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("mid_reset no_done", 32'(done_cnt - d0), 32'd0);
        run_frame(vecs[0], "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
